// File: rtl/skew_feed_ctrl.sv
// Loads an NxN tile row by row, then streams it diagonally so that lane i
// trails lane 0 by i cycles, followed by a fixed drain period.
module skew_feed_ctrl #(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int DRAIN = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_row,
    output logic [N*W-1:0] lane_data,
    output logic [N-1:0]   lane_valid,
    output logic           busy,
    output logic           done
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (N > 1) ? $clog2(2 * N - 1) : 1;
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [RW-1:0] R_LAST = RW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(2 * N - 2);
    localparam logic [DW-1:0] D_LAST = DW'((DRAIN > 0) ? DRAIN - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   r, r_nx;
    logic [KW-1:0]   k, k_nx;
    logic [DW-1:0]   d, d_nx;
    logic            wr_en;
    logic [N-1:0][N*W-1:0] tile;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            r     <= '0;
            k     <= '0;
            d     <= '0;
        end else begin
            state <= state_nx;
            r     <= r_nx;
            k     <= k_nx;
            d     <= d_nx;
        end
    end

    // Tile storage is deliberately unreset; it is only read in FEED, after a full load.
    always_ff @(posedge clk) begin
        if (wr_en) tile[r] <= in_row;
    end

    always_comb begin
        state_nx = state;
        r_nx     = r;
        k_nx     = k;
        d_nx     = d;
        wr_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (r == R_LAST) begin
                        r_nx     = '0;
                        k_nx     = '0;
                        state_nx = S_FEED;
                    end else begin
                        r_nx = r + RW'(1);
                    end
                end
            end
            S_FEED: begin
                if (k == K_LAST) begin
                    k_nx     = '0;
                    d_nx     = '0;
                    state_nx = (DRAIN == 0) ? S_DONE : S_DRAIN;
                end else begin
                    k_nx = k + KW'(1);
                end
            end
            S_DRAIN: begin
                if (d == D_LAST) begin
                    d_nx     = '0;
                    state_nx = S_DONE;
                end else begin
                    d_nx = d + DW'(1);
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides everything, including a coincident final row accept.
        if (abort) begin
            state_nx = S_IDLE;
            r_nx     = '0;
            k_nx     = '0;
            d_nx     = '0;
            wr_en    = 1'b0;
        end
    end

    // Diagonal decode: lane i shows row k-i while that row index is in range.
    always_comb begin
        int diff;
        diff       = 0;
        lane_data  = '0;
        lane_valid = '0;
        if (state == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                diff = int'(k) - i;
                if (diff >= 0 && diff < N) begin
                    lane_valid[i]        = 1'b1;
                    lane_data[i*W +: W]  = tile[diff[RW-1:0]][i*W +: W];
                end
            end
        end
    end

    assign busy     = (state != S_IDLE);
    assign in_ready = (state == S_LOAD);
    assign done     = (state == S_DONE);

endmodule
